// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - instruction prefetch queue feeding the decoder.
// Optional same-cycle ack-to-decoder bypass is enabled by defining FETCH_BYPASS_EN.
module fetch_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          i_pc_set,
  input  logic [AW-1:0] i_pc_value,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  input  logic          i_mem_ack,
  input  logic [15:0]   i_mem_data,
  output logic [15:0]   o_inst_word,
  output logic          o_inst_valid,
  input  logic          i_inst_ready,
  output logic [AW-1:0] o_fetch_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state, state_next;
  logic [AW-1:0] fetch_addr, fetch_inc, mem_addr;
  logic [15:0]   data_q [DEPTH];
  logic [AW-1:0] pc_q   [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_next;
  logic          ack_ok, q_valid, pop, push, bypass;

  assign fetch_inc = fetch_addr + 1'b1;
  assign ack_ok    = (state == REQ) && i_mem_ack && !i_pc_set;
  assign q_valid   = (count != '0);
  assign pop       = q_valid && i_inst_ready && !i_pc_set;

`ifdef FETCH_BYPASS_EN
  assign bypass = ack_ok && !q_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that the decoder takes never enters the queue.
  assign push = ack_ok && !(bypass && i_inst_ready);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    if (i_pc_set) begin
      case (state)
        IDLE:    state_next = REQ;
        default: state_next = i_mem_ack ? REQ : DRAIN;
      endcase
    end else begin
      case (state)
        IDLE:    if (count < FULL) state_next = REQ;
        REQ:     if (i_mem_ack) state_next = (count_next < FULL) ? REQ : IDLE;
        DRAIN:   if (i_mem_ack) state_next = REQ;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      fetch_addr <= '0;
      mem_addr   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state <= state_next;
      if (i_pc_set) begin
        fetch_addr <= i_pc_value;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        // DRAIN keeps the old address on the bus until its ack returns.
        if (state_next == REQ) mem_addr <= i_pc_value;
      end else begin
        if (ack_ok) fetch_addr <= fetch_inc;
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (pop)    rd_ptr <= rd_ptr + 1'b1;
        count <= count_next;
        if (state_next == REQ) mem_addr <= ack_ok ? fetch_inc : fetch_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !i_pc_set) begin
      data_q[wr_ptr] <= i_mem_data;
      pc_q[wr_ptr]   <= fetch_addr;
    end
  end

  assign o_mem_req    = (state != IDLE);
  assign o_mem_addr   = mem_addr;
  assign o_inst_valid = q_valid || bypass;
  assign o_inst_word  = q_valid ? data_q[rd_ptr] : (bypass ? i_mem_data : 16'h0000);
  assign o_fetch_pc   = q_valid ? pc_q[rd_ptr]   : (bypass ? fetch_addr : '0);

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed bench for fetch_prefetch_queue.
// Auto-memory returns addr ^ 16'h5A00; manual acks are used around redirects.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        pc_set;
  logic [15:0] pc_value;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] inst_word;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] fetch_pc;
  logic        mem_en;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] pop_pc[$];
  logic [15:0] pop_word[$];

  fetch_prefetch_queue #(.DEPTH(4), .AW(16)) dut (
    .clk(clk), .n_rst(n_rst), .i_pc_set(pc_set), .i_pc_value(pc_value),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack),
    .i_mem_data(mem_data), .o_inst_word(inst_word), .o_inst_valid(inst_valid),
    .i_inst_ready(inst_ready), .o_fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: log decoder handshakes, then let the auto-memory answer.
  task automatic step();
    @(negedge clk);
    if (inst_valid && inst_ready) begin
      pop_pc.push_back(fetch_pc);
      pop_word.push_back(inst_word);
    end
    @(posedge clk);
    #1;
    if (mem_en) begin
      if (mem_req && !mem_ack) begin
        mem_ack  = 1'b1;
        mem_data = mem_addr ^ 16'h5A00;
      end else begin
        mem_ack = 1'b0;
      end
    end
  endtask

  task automatic chk_log(input string tag, input logic [15:0] base, input int n);
    logic [15:0] a;
    chk({tag, "_count"}, 32'(pop_pc.size() >= n), 32'd1);
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      chk({tag, "_pc"},   (i < pop_pc.size())   ? 32'(pop_pc[i])   : 32'hFFFF_FFFF, 32'(a));
      chk({tag, "_word"}, (i < pop_word.size()) ? 32'(pop_word[i]) : 32'hFFFF_FFFF, 32'(a ^ 16'h5A00));
    end
  endtask

  initial begin
    n_rst = 1'b0; pc_set = 1'b0; pc_value = '0; mem_ack = 1'b0; mem_data = '0;
    inst_ready = 1'b1; mem_en = 1'b0;
    step(); step();
    chk("rst_req",   32'(mem_req),    32'd0);
    chk("rst_addr",  32'(mem_addr),   32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_word",  32'(inst_word),  32'd0);
    chk("rst_pc",    32'(fetch_pc),   32'd0);

    // Streaming from 0 with the decoder always ready.
    mem_en = 1'b1; n_rst = 1'b1;
    for (int n = 0; n < 40 && pop_pc.size() < 4; n++) step();
    chk_log("stream", 16'h0000, 4);

    // Stall: the queue fills to DEPTH and requests stop.
    inst_ready = 1'b0; pc_value = 16'h0100; pc_set = 1'b1;
    step();
    pc_set = 1'b0;
    repeat (30) step();
    chk("stall_req",   32'(mem_req),    32'd0);
    chk("stall_count", 32'(dut.count),  32'd4);
    chk("stall_valid", 32'(inst_valid), 32'd1);
    chk("stall_pc",    32'(fetch_pc),   32'h0100);
    chk("stall_word",  32'(inst_word),  32'h5B00);
    pop_pc.delete(); pop_word.delete();
    inst_ready = 1'b1;
    for (int n = 0; n < 60 && pop_pc.size() < 6; n++) step();
    chk_log("resume", 16'h0100, 6);

    // Redirect while the request to 5 is still outstanding.
    mem_en = 1'b0; mem_ack = 1'b0; n_rst = 1'b0;
    step();
    n_rst = 1'b1; pc_set = 1'b1; pc_value = 16'h0005; inst_ready = 1'b0;
    step();
    pc_set = 1'b0;
    chk("redir_req",  32'(mem_req),  32'd1);
    chk("redir_addr", 32'(mem_addr), 32'h0005);
    step();
    chk("hold_addr",  32'(mem_addr), 32'h0005);
    pc_set = 1'b1; pc_value = 16'h0040;
    step();
    pc_set = 1'b0;
    chk("drain_req",  32'(mem_req),  32'd1);
    chk("drain_addr", 32'(mem_addr), 32'h0005);
    mem_ack = 1'b1; mem_data = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    chk("discard_valid", 32'(inst_valid), 32'd0);
    chk("new_addr",      32'(mem_addr),   32'h0040);
    mem_ack = 1'b1; mem_data = 16'hA55A;
    #1;
`ifdef FETCH_BYPASS_EN
    chk("byp_valid", 32'(inst_valid), 32'd1);
    chk("byp_word",  32'(inst_word),  32'hA55A);
    chk("byp_pc",    32'(fetch_pc),   32'h0040);
`else
    chk("nobyp_valid", 32'(inst_valid), 32'd0);
`endif
    step();
    mem_ack = 1'b0;
    chk("first_valid", 32'(inst_valid), 32'd1);
    chk("first_word",  32'(inst_word),  32'hA55A);
    chk("first_pc",    32'(fetch_pc),   32'h0040);
    chk("next_addr",   32'(mem_addr),   32'h0041);

    // Flush coincident with ack and pop at count=2.
    mem_ack = 1'b1; mem_data = 16'h1111;
    step();
    mem_ack = 1'b0;
    chk("two_count", 32'(dut.count), 32'd2);
    pc_set = 1'b1; pc_value = 16'h0080; mem_ack = 1'b1; mem_data = 16'h2222; inst_ready = 1'b1;
    step();
    pc_set = 1'b0; mem_ack = 1'b0;
    chk("flush_count", 32'(dut.count),  32'd0);
    chk("flush_valid", 32'(inst_valid), 32'd0);
    chk("flush_req",   32'(mem_req),    32'd1);
    chk("flush_addr",  32'(mem_addr),   32'h0080);
    step();
    chk("flush_valid2", 32'(inst_valid), 32'd0);

    // Address wrap at the top of memory.
    pc_set = 1'b1; pc_value = 16'hFFFE;
    step();
    pc_set = 1'b0;
    pop_pc.delete(); pop_word.delete();
    mem_en = 1'b1;
    for (int n = 0; n < 40 && pop_pc.size() < 3; n++) step();
    chk_log("wrap", 16'hFFFE, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
